// File: rtl/conv1d_mem_arbiter.sv
// SRAM arbiter/sequencer for the conv1d accelerator: shares one single-port SRAM between the
// external shim and the datapath, with an accelerator lock and starvation guard. Optional
// stall statistics are enabled with `define CONV1D_ARB_STATS_EN.
module conv1d_mem_arbiter #(
  parameter int AddrWidth = 7,
  parameter int DataWidth = 32,
  parameter int MaxWait   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ext_req_i,
  input  logic                   ext_we_i,
  input  logic [AddrWidth-1:0]   ext_addr_i,
  input  logic [DataWidth-1:0]   ext_wdata_i,
  input  logic [DataWidth/8-1:0] ext_be_i,
  output logic                   ext_gnt_o,
  output logic                   ext_rvalid_o,
  input  logic                   acc_req_i,
  input  logic                   acc_we_i,
  input  logic [AddrWidth-1:0]   acc_addr_i,
  input  logic [DataWidth-1:0]   acc_wdata_i,
  input  logic [DataWidth/8-1:0] acc_be_i,
  output logic                   acc_gnt_o,
  output logic                   acc_rvalid_o,
  input  logic                   acc_lock_req_i,
  output logic                   acc_lock_ack_o,
  output logic                   sram_req_o,
  output logic                   sram_we_o,
  output logic [AddrWidth-1:0]   sram_addr_o,
  output logic [DataWidth-1:0]   sram_wdata_o,
  output logic [DataWidth/8-1:0] sram_be_o,
  input  logic [DataWidth-1:0]   sram_rdata_i
`ifdef CONV1D_ARB_STATS_EN
  ,
  input  logic                   stall_clr_i,
  output logic [15:0]            stall_cnt_o
`endif
);

  typedef enum logic [1:0] {FREE, LOCK_PEND, LOCKED} state_t;

  localparam logic [7:0] WaitLimit = 8'(MaxWait - 1);

  state_t     state, state_next;
  logic       last_acc;
  logic [7:0] starv_cnt;
  logic [1:0] pending;

  assign ext_rvalid_o   = pending[0];
  assign acc_rvalid_o   = pending[1];
  assign acc_lock_ack_o = (state == LOCKED);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= FREE;
    else       state <= state_next;
  end

  // Grants are combinational so a request is accepted in the cycle it is presented.
  always_comb begin
    state_next = state;
    ext_gnt_o  = 1'b0;
    acc_gnt_o  = 1'b0;
    if (!rst_i) begin
      unique case (state)
        FREE: begin
          if (ext_req_i && acc_req_i) begin
            ext_gnt_o = last_acc;
            acc_gnt_o = !last_acc;
          end else begin
            ext_gnt_o = ext_req_i;
            acc_gnt_o = acc_req_i;
          end
          if (acc_lock_req_i) state_next = LOCK_PEND;
        end
        LOCK_PEND: begin
          acc_gnt_o = acc_req_i;
          if (!acc_lock_req_i)   state_next = FREE;
          else if (!pending[0])  state_next = LOCKED;
        end
        LOCKED: begin
          if (ext_req_i && (!acc_req_i || starv_cnt == WaitLimit)) ext_gnt_o = 1'b1;
          else                                                    acc_gnt_o = acc_req_i;
          if (!acc_lock_req_i) state_next = FREE;
        end
        default: state_next = FREE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_acc  <= 1'b0;
      starv_cnt <= 8'd0;
      pending   <= 2'b00;
    end else begin
      if (ext_gnt_o)      last_acc <= 1'b0;
      else if (acc_gnt_o) last_acc <= 1'b1;
      if (!ext_req_i || ext_gnt_o)   starv_cnt <= 8'd0;
      else if (starv_cnt != WaitLimit) starv_cnt <= starv_cnt + 8'd1;
      pending <= {acc_gnt_o && !acc_we_i, ext_gnt_o && !ext_we_i};
    end
  end

  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (ext_gnt_o) begin
      sram_req_o   = 1'b1;
      sram_we_o    = ext_we_i;
      sram_addr_o  = ext_addr_i;
      sram_wdata_o = ext_wdata_i;
      sram_be_o    = ext_be_i;
    end else if (acc_gnt_o) begin
      sram_req_o   = 1'b1;
      sram_we_o    = acc_we_i;
      sram_addr_o  = acc_addr_i;
      sram_wdata_o = acc_wdata_i;
      sram_be_o    = acc_be_i;
    end
  end

`ifdef CONV1D_ARB_STATS_EN
  // A stall is a cycle where both sides asked and only one could be served.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)            stall_cnt_o <= 16'd0;
    else if (stall_clr_i) stall_cnt_o <= 16'd0;
    else if (ext_req_i && acc_req_i && (ext_gnt_o || acc_gnt_o) && stall_cnt_o != 16'hFFFF)
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_conv1d_mem_arbiter.sv
// Self-checking bench for conv1d_mem_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model with its own reference memory.
module tb_conv1d_mem_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int MaxWait = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          ext_req_i = 0, ext_we_i = 0;
  logic [AW-1:0] ext_addr_i = 0;
  logic [DW-1:0] ext_wdata_i = 0;
  logic [3:0]    ext_be_i = 0;
  logic          ext_gnt_o, ext_rvalid_o;
  logic          acc_req_i = 0, acc_we_i = 0;
  logic [AW-1:0] acc_addr_i = 0;
  logic [DW-1:0] acc_wdata_i = 0;
  logic [3:0]    acc_be_i = 0;
  logic          acc_gnt_o, acc_rvalid_o;
  logic          acc_lock_req_i = 0;
  logic          acc_lock_ack_o;
  logic          sram_req_o, sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [3:0]    sram_be_o;
  logic [DW-1:0] sram_rdata_i = 0;
  logic          stall_clr_i = 0;
  logic [15:0]   stall_cnt_o;

  conv1d_mem_arbiter #(.AddrWidth(AW), .DataWidth(DW), .MaxWait(MaxWait)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i),
    .ext_wdata_i(ext_wdata_i), .ext_be_i(ext_be_i), .ext_gnt_o(ext_gnt_o),
    .ext_rvalid_o(ext_rvalid_o),
    .acc_req_i(acc_req_i), .acc_we_i(acc_we_i), .acc_addr_i(acc_addr_i),
    .acc_wdata_i(acc_wdata_i), .acc_be_i(acc_be_i), .acc_gnt_o(acc_gnt_o),
    .acc_rvalid_o(acc_rvalid_o),
    .acc_lock_req_i(acc_lock_req_i), .acc_lock_ack_o(acc_lock_ack_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
`ifdef CONV1D_ARB_STATS_EN
    , .stall_clr_i(stall_clr_i), .stall_cnt_o(stall_cnt_o)
`endif
  );

`ifndef CONV1D_ARB_STATS_EN
  assign stall_cnt_o = 16'd0;
`endif

  always #5 clk_i = ~clk_i;

  // SRAM stub driven purely by the DUT's SRAM port.
  logic [DW-1:0] sram_mem [128];
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_be_o[b]) sram_mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
      end else begin
        sram_rdata_i <= sram_mem[sram_addr_o];
      end
    end
  end

  int check_cnt = 0;
  int pass_cnt  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: 0 = free, 1 = lock pending, 2 = locked
  int            m_mode;
  bit            m_last_acc;
  int            m_waited;
  bit            m_rv_ext, m_rv_acc;
  logic [DW-1:0] m_rdata;
  int            m_stall;
  logic [DW-1:0] ref_mem [128];

  task automatic modelReset();
    m_mode = 0; m_last_acc = 0; m_waited = 0;
    m_rv_ext = 0; m_rv_acc = 0; m_stall = 0;
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance the model at the rising edge.
  task automatic applyStimulus(input logic er, input logic ew, input logic [AW-1:0] ea,
                               input logic ar, input logic aw, input logic [AW-1:0] aa,
                               input logic lk);
    bit eg, ag;
    logic [DW-1:0] wd;
    logic [3:0] be;
    ext_req_i = er; ext_we_i = ew; ext_addr_i = ea;
    ext_wdata_i = $urandom; ext_be_i = 4'($urandom);
    acc_req_i = ar; acc_we_i = aw; acc_addr_i = aa;
    acc_wdata_i = $urandom; acc_be_i = 4'($urandom);
    acc_lock_req_i = lk;
    @(negedge clk_i);
    eg = 0; ag = 0;
    if (m_mode == 0) begin
      if (er && ar) begin eg = m_last_acc; ag = !m_last_acc; end
      else begin eg = er; ag = ar; end
    end else if (m_mode == 1) begin
      ag = ar;
    end else begin
      if (er && (!ar || m_waited >= MaxWait - 1)) eg = 1;
      else ag = ar;
    end
    checkOutput("ext_gnt", ext_gnt_o, eg);
    checkOutput("acc_gnt", acc_gnt_o, ag);
    checkOutput("ext_rvalid", ext_rvalid_o, m_rv_ext);
    checkOutput("acc_rvalid", acc_rvalid_o, m_rv_acc);
    if (m_rv_ext || m_rv_acc) checkOutput("rdata", sram_rdata_i, m_rdata);
    checkOutput("lock_ack", acc_lock_ack_o, m_mode == 2);
    checkOutput("sram_req", sram_req_o, eg || ag);
    checkOutput("sram_we", sram_we_o, eg ? ew : (ag ? aw : 1'b0));
    checkOutput("sram_addr", sram_addr_o, eg ? ea : (ag ? aa : '0));
    wd = eg ? ext_wdata_i : (ag ? acc_wdata_i : '0);
    be = eg ? ext_be_i : (ag ? acc_be_i : '0);
    checkOutput("sram_wdata", sram_wdata_o, wd);
    checkOutput("sram_be", sram_be_o, be);
`ifdef CONV1D_ARB_STATS_EN
    checkOutput("stall_cnt", stall_cnt_o, m_stall);
`endif
    @(posedge clk_i);
    if (eg || ag) begin
      logic [AW-1:0] a;
      logic          w;
      a = eg ? ea : aa;
      w = eg ? ew : aw;
      if (w) begin
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
      end else m_rdata = ref_mem[a];
    end
    case (m_mode)
      0: if (lk) m_mode = 1;
      1: if (!lk) m_mode = 0; else if (!m_rv_ext) m_mode = 2;
      default: if (!lk) m_mode = 0;
    endcase
    m_rv_ext = eg && !ew;
    m_rv_acc = ag && !aw;
    if (eg) m_last_acc = 0;
    else if (ag) m_last_acc = 1;
    if (!er || eg) m_waited = 0;
    else if (m_waited < MaxWait - 1) m_waited++;
    if (stall_clr_i) m_stall = 0;
    else if (er && ar && (eg || ag) && m_stall < 16'hFFFF) m_stall++;
    #1;
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    ext_req_i = 1'b1; acc_req_i = 1'b1;
    #1;
    checkOutput("rst_ext_gnt", ext_gnt_o, 1'b0);
    checkOutput("rst_acc_gnt", acc_gnt_o, 1'b0);
    checkOutput("rst_ext_rvalid", ext_rvalid_o, 1'b0);
    checkOutput("rst_acc_rvalid", acc_rvalid_o, 1'b0);
    checkOutput("rst_lock_ack", acc_lock_ack_o, 1'b0);
    checkOutput("rst_sram_req", sram_req_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    modelReset();
  endtask

  initial begin
    bit lk;
    for (int i = 0; i < 128; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    sram_mem[5] = 32'hDEADBEEF;
    ref_mem[5]  = 32'hDEADBEEF;
    modelReset();
    @(posedge clk_i);
    #1;
    doReset();

    // Single external read of a known word.
    applyStimulus(1, 0, 7'h05, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("deadbeef", m_rdata, 32'hDEADBEEF);

    // Contention in FREE alternates acc, ext, acc, ext.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 7'(i), 1, 0, 7'(i + 8), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Lock request while an external read is still returning.
    applyStimulus(1, 0, 7'h05, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 7'h06, 0, 0, 0, 1);

    // Starvation guard under continuous accelerator traffic.
    for (int i = 0; i < 40; i++) applyStimulus(1, 0, 7'(i), 1, 0, 7'(i + 1), 1);

    // Reset while an accelerator read is in flight under lock.
    applyStimulus(0, 0, 0, 1, 0, 7'h05, 1);
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Contention statistics and clear.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 7'(i), 1, 1, 7'(i), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    stall_clr_i = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    stall_clr_i = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with lock phases.
    lk = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) lk = !lk;
      stall_clr_i = ($urandom_range(0, 199) == 0);
      applyStimulus($urandom_range(0, 9) < 6, 1'($urandom), 7'($urandom),
                    $urandom_range(0, 9) < 7, 1'($urandom), 7'($urandom), lk);
      if ($urandom_range(0, 499) == 0) doReset();
    end
    stall_clr_i = 1'b0;

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
